// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - in-order instruction fetch stage with redirect, stale-response drop and decode pre-slicing
//
// Ports:
//   clk, rst_n                     clock (rising edge), synchronous active-low reset
//   imem_req_valid/ready/addr      fetch request channel, address = current PC
//   imem_rsp_valid/data            in-order instruction responses, one per accepted request
//   redirect_valid/target          taken branch/jump from execute
//   if_valid/ready                 handshake to decode
//   if_instr, if_pc, if_pc_plus4   head instruction and its PC
//   if_op, if_funct3, if_funct7    pre-sliced fields of if_instr

module instr_fetch_unit #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [DATA_WIDTH-1:0] imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [DATA_WIDTH-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [DATA_WIDTH-1:0] redirect_target,
    output logic                  if_valid,
    input  logic                  if_ready,
    output logic [DATA_WIDTH-1:0] if_instr,
    output logic [DATA_WIDTH-1:0] if_pc,
    output logic [DATA_WIDTH-1:0] if_pc_plus4,
    output logic [6:0]            if_op,
    output logic [2:0]            if_funct3,
    output logic [6:0]            if_funct7
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] L_DEPTH = (CW+1)'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] r_pc;
    logic [CW-1:0]         r_outstanding;
    logic [CW-1:0]         r_drop_cnt;
    logic [CW-1:0]         r_count;
    logic [AW-1:0]         r_wptr;
    logic [AW-1:0]         r_rptr;
    logic [AW-1:0]         r_req_wptr;
    logic [AW-1:0]         r_req_rptr;

    logic [DATA_WIDTH-1:0] r_instr_mem  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_ipc_mem    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] r_req_pc_mem [FIFO_DEPTH];

    logic                  w_room;
    logic                  w_issue;
    logic                  w_drop;
    logic                  w_push;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_rsp_pc;
    logic                  w_unused_tgt_lsb;

    // Outstanding plus buffered never exceeds the FIFO depth, so every
    // response has a guaranteed slot and no response-side backpressure exists.
    assign w_room  = ({1'b0, r_outstanding} + {1'b0, r_count}) < L_DEPTH;
    assign imem_req_valid = rst_n & ~redirect_valid & w_room;
    assign imem_req_addr  = r_pc;
    assign w_issue = imem_req_valid & imem_req_ready;

    // A response in a redirect cycle is stale by definition; it is not pushed
    // and is accounted for through the drop counter reload below.
    assign w_drop  = imem_rsp_valid & (r_drop_cnt != '0);
    assign w_push  = imem_rsp_valid & ~redirect_valid & (r_drop_cnt == '0);

    assign if_valid = rst_n & (r_count != '0) & ~redirect_valid;
    assign w_pop    = if_valid & if_ready;

    // Side FIFO of issued PCs: popped by every response, kept or dropped,
    // so its head always pairs with the response on the bus.
    assign w_rsp_pc = r_req_pc_mem[r_req_rptr];

    assign if_instr    = r_instr_mem[r_rptr];
    assign if_pc       = r_ipc_mem[r_rptr];
    assign if_pc_plus4 = if_pc + DATA_WIDTH'(4);
    assign if_op       = if_instr[6:0];
    assign if_funct3   = if_instr[14:12];
    assign if_funct7   = if_instr[31:25];

    assign w_unused_tgt_lsb = ^redirect_target[1:0];

    always_ff @(posedge clk) begin
        if (w_issue) begin
            r_req_pc_mem[r_req_wptr] <= r_pc;
        end
        if (w_push) begin
            r_instr_mem[r_wptr] <= imem_rsp_data;
            r_ipc_mem[r_wptr]   <= w_rsp_pc;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_count       <= '0;
            r_wptr        <= '0;
            r_rptr        <= '0;
            r_req_wptr    <= '0;
            r_req_rptr    <= '0;
        end else begin
            if (w_issue) begin
                r_req_wptr <= r_req_wptr + AW'(1);
            end
            if (imem_rsp_valid) begin
                r_req_rptr <= r_req_rptr + AW'(1);
            end
            r_outstanding <= r_outstanding + CW'(w_issue) - CW'(imem_rsp_valid);

            if (redirect_valid) begin
                r_pc    <= {redirect_target[DATA_WIDTH-1:2], 2'b00};
                r_count <= '0;
                r_wptr  <= '0;
                r_rptr  <= '0;
                // Every request still in flight after this edge is stale.
                // drop_cnt is always a subset of outstanding, so reloading from
                // outstanding (rather than adding) keeps back-to-back redirects
                // from counting the same request twice.
                r_drop_cnt <= r_outstanding - CW'(imem_rsp_valid);
            end else begin
                if (w_issue) begin
                    r_pc <= r_pc + DATA_WIDTH'(4);
                end
                if (w_drop) begin
                    r_drop_cnt <= r_drop_cnt - CW'(1);
                end
                if (w_push) begin
                    r_wptr <= r_wptr + AW'(1);
                end
                if (w_pop) begin
                    r_rptr <= r_rptr + AW'(1);
                end
                r_count <= r_count + CW'(w_push) - CW'(w_pop);
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb/tb_instr_fetch_unit.sv - directed scoreboard bench for instr_fetch_unit

module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] if_pc_plus4;
    logic [6:0]  if_op;
    logic [2:0]  if_funct3;
    logic [6:0]  if_funct7;

    instr_fetch_unit #(
        .DATA_WIDTH (32),
        .RESET_PC   (RESET_PC),
        .FIFO_DEPTH (2)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_req_addr   (imem_req_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .if_valid        (if_valid),
        .if_ready        (if_ready),
        .if_instr        (if_instr),
        .if_pc           (if_pc),
        .if_pc_plus4     (if_pc_plus4),
        .if_op           (if_op),
        .if_funct3       (if_funct3),
        .if_funct7       (if_funct7)
    );

    always #5 clk = ~clk;

    int          vectors = 0;
    int          errs    = 0;
    int          cyc     = 0;
    int          lat     = 1;
    int          n_req   = 0;
    int          n_pop   = 0;
    logic [31:0] exp_pc;
    logic        first_chk;
    logic        last_rsp;
    logic        rnd_ready;

    logic [31:0] pend_addr[$];
    int          pend_due[$];
    logic [31:0] sb_pc[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return 32'hC0DE_0000 ^ a;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: present any due IMEM response, check at the falling
    // edge, then advance past the rising edge.
    task automatic tick();
        logic [31:0] p;
        logic [31:0] w;
        if (rst_n && pend_due.size() > 0 && pend_due[0] <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(pend_addr[0]);
            void'(pend_addr.pop_front());
            void'(pend_due.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = 32'hDEAD_BEEF;
        end
        if (rnd_ready) imem_req_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        last_rsp = imem_rsp_valid;
        if (!rst_n) begin
            check("rst_if_valid", {31'b0, if_valid}, 32'd0);
            check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
            sb_pc.delete();
            pend_addr.delete();
            pend_due.delete();
            exp_pc    = RESET_PC;
            first_chk = 1'b1;
            n_req     = 0;
            n_pop     = 0;
        end else begin
            if (first_chk) begin
                check("first_req_valid", {31'b0, imem_req_valid}, 32'd1);
                check("first_req_addr", imem_req_addr, RESET_PC);
                first_chk = 1'b0;
            end
            if (redirect_valid) begin
                check("redir_if_valid", {31'b0, if_valid}, 32'd0);
                check("redir_req_valid", {31'b0, imem_req_valid}, 32'd0);
            end
            if (imem_req_valid && imem_req_ready) begin
                check("req_addr", imem_req_addr, exp_pc);
                pend_addr.push_back(exp_pc);
                pend_due.push_back(cyc + lat);
                sb_pc.push_back(exp_pc);
                exp_pc = exp_pc + 32'd4;
                n_req++;
            end
            if (if_valid && if_ready) begin
                check("sb_nonempty", {31'b0, sb_pc.size() != 0}, 32'd1);
                if (sb_pc.size() != 0) begin
                    p = sb_pc.pop_front();
                    w = mem_word(p);
                    check("if_pc", if_pc, p);
                    check("if_instr", if_instr, w);
                    check("if_pc_plus4", if_pc_plus4, p + 32'd4);
                    check("if_op", {25'b0, if_op}, {25'b0, w[6:0]});
                    check("if_funct3", {29'b0, if_funct3}, {29'b0, w[14:12]});
                    check("if_funct7", {25'b0, if_funct7}, {25'b0, w[31:25]});
                    if (p == 32'h10) begin
                        check("dec_op_addi", {25'b0, if_op}, 32'h13);
                        check("dec_f3_addi", {29'b0, if_funct3}, 32'h0);
                        check("dec_f7_addi", {25'b0, if_funct7}, 32'h0);
                    end
                    n_pop++;
                end
            end
            if (redirect_valid) begin
                sb_pc.delete();
                exp_pc = {redirect_target[31:2], 2'b00};
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = '0;
        redirect_valid  = 1'b0;
        redirect_target = '0;
        if_ready        = 1'b1;
        exp_pc          = RESET_PC;
        first_chk       = 1'b0;
        last_rsp        = 1'b0;
        rnd_ready       = 1'b0;
        @(posedge clk);
        #1;

        // Streaming with 1-cycle latency, then a stretch of random IMEM stalls
        lat = 1;
        do_reset();
        repeat (20) tick();
        check("s1_pops", {31'b0, n_pop >= 10}, 32'd1);
        rnd_ready = 1'b1;
        repeat (30) tick();
        rnd_ready      = 1'b0;
        imem_req_ready = 1'b1;
        repeat (4) tick();

        // Decode backpressure: exactly two requests, then fetch stalls
        do_reset();
        if_ready = 1'b0;
        repeat (8) tick();
        check("bp_req_count", n_req, 32'd2);
        check("bp_req_valid_low", {31'b0, imem_req_valid}, 32'd0);
        check("bp_if_valid", {31'b0, if_valid}, 32'd1);
        if_ready = 1'b1;
        repeat (12) tick();
        check("bp_resume", {31'b0, n_pop >= 4}, 32'd1);

        // Redirect with two requests outstanding at latency 3
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        tick();
        redirect_valid  = 1'b0;
        repeat (20) tick();
        check("s3_pops", {31'b0, n_pop >= 3}, 32'd1);

        // Redirect colliding with a response and an offered head
        lat = 1;
        do_reset();
        if_ready = 1'b0;
        tick();
        tick();
        if_ready        = 1'b1;
        redirect_valid  = 1'b1;
        redirect_target = 32'h103;
        tick();
        check("s4_rsp_in_redirect", {31'b0, last_rsp}, 32'd1);
        redirect_valid = 1'b0;
        repeat (12) tick();
        check("s4_pops", {31'b0, n_pop >= 3}, 32'd1);

        // Back-to-back redirects, only the second stream survives
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        tick();
        redirect_target = 32'h300;
        tick();
        redirect_valid  = 1'b0;
        repeat (24) tick();
        check("s5_pops", {31'b0, n_pop >= 4}, 32'd1);

        // Reset while the FIFO is full
        lat = 1;
        do_reset();
        if_ready = 1'b0;
        repeat (5) tick();
        check("s6_full_valid", {31'b0, if_valid}, 32'd1);
        rst_n = 1'b0;
        tick();
        rst_n    = 1'b1;
        if_ready = 1'b1;
        repeat (12) tick();
        check("s6_pops", {31'b0, n_pop >= 3}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
